// File: rtl/fnd_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : fnd_scan_controller
// Brief    : Binary-to-BCD conversion (sequential double-dabble) and 4-digit
//            time-multiplexed scan driver for the FND decoder stage.
//            Optional macro FND_LEADING_ZERO_BLANK_EN blanks leading zeros.
// Revision : 1.0 - initial release
// ============================================================================
module fnd_scan_controller #(
    parameter int PRESCALE = 100000,
    parameter int CNT_W    = 17
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [13:0] i_value,
    input  logic        i_load,
    input  logic        i_display_on,
    output logic        o_busy,
    output logic        o_overflow,
    output logic [1:0]  o_digit_position,
    output logic        o_En,
    output logic [3:0]  o_value
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_PRESC_MAX = CNT_W'(PRESCALE - 1);
    localparam logic [13:0]      c_MAX_VAL   = 14'd9999;
    localparam logic [3:0]       c_LAST_SHIFT = 4'd13;

    state_t       state_q, state_d;
    logic [13:0]  bin_q, bin_d;
    logic [15:0]  bcd_q, bcd_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [15:0]  disp_q, disp_d;
    logic         ovf_q, ovf_d;
    logic [15:0]  w_adj;

    logic [CNT_W-1:0] presc_q;
    logic [1:0]       digit_q;
    logic             en_q;

    // Add-3 correction applied to every nibble before each shift.
    always_comb begin
        w_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (i_load) begin
                    bin_d   = (i_value > c_MAX_VAL) ? c_MAX_VAL : i_value;
                    ovf_d   = (i_value > c_MAX_VAL);
                    bcd_d   = 16'h0000;
                    cnt_d   = 4'd0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                bcd_d = {w_adj[14:0], bin_q[13]};
                bin_d = {bin_q[12:0], 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == c_LAST_SHIFT) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                disp_d  = bcd_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            bin_q   <= 14'd0;
            bcd_q   <= 16'h0000;
            cnt_q   <= 4'd0;
            disp_q  <= 16'h0000;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
        end
    end

    // Free-running scan: independent of conversion and display enable.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            presc_q <= '0;
            digit_q <= 2'd0;
            en_q    <= 1'b0;
        end else begin
            en_q <= i_display_on;
            if (presc_q == c_PRESC_MAX) begin
                presc_q <= '0;
                digit_q <= digit_q + 2'd1;
            end else begin
                presc_q <= presc_q + 1'b1;
            end
        end
    end

`ifdef FND_LEADING_ZERO_BLANK_EN
    logic [3:0] lit_q;
    logic [3:0] w_lit;

    always_comb begin
        w_lit    = 4'b0001;
        w_lit[3] = (disp_q[15:12] != 4'd0);
        w_lit[2] = (disp_q[15:8]  != 8'd0);
        w_lit[1] = (disp_q[15:4]  != 12'd0);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            lit_q <= 4'b0001;
        end else begin
            lit_q <= w_lit;
        end
    end

    assign o_En = en_q & lit_q[digit_q];
`else
    assign o_En = en_q;
`endif

    assign o_busy           = (state_q != S_IDLE);
    assign o_overflow       = ovf_q;
    assign o_digit_position = digit_q;
    assign o_value          = disp_q[{digit_q, 2'b00} +: 4];

endmodule
`default_nettype wire

// File: tb/tb_fnd_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_fnd_scan_controller
// Brief    : Directed self-checking bench for fnd_scan_controller (PRESCALE=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fnd_scan_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] i_value = 14'd0;
    logic        i_load = 1'b0;
    logic        i_display_on = 1'b0;
    logic        o_busy;
    logic        o_overflow;
    logic [1:0]  o_digit_position;
    logic        o_En;
    logic [3:0]  o_value;

    int vectors = 0;
    int errors  = 0;

    fnd_scan_controller #(
        .PRESCALE (4),
        .CNT_W    (3)
    ) dut (
        .i_clk            (clk),
        .i_reset_n        (rst_n),
        .i_value          (i_value),
        .i_load           (i_load),
        .i_display_on     (i_display_on),
        .o_busy           (o_busy),
        .o_overflow       (o_overflow),
        .o_digit_position (o_digit_position),
        .o_En             (o_En),
        .o_value          (o_value)
    );

    always #5 clk = ~clk;

    task automatic do_load(input logic [13:0] v);
        @(negedge clk);
        i_value = v;
        i_load  = 1'b1;
        @(negedge clk);
        i_load  = 1'b0;
    endtask

    // Returns once busy drops; n = number of sampled busy cycles.
    task automatic count_busy(output int n);
        n = 0;
        while (o_busy && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Collect the nibble and enable shown at each scan position.
    task automatic read_digits(output logic [15:0] vals, output logic [3:0] ens,
                               output bit timeout);
        int w;
        vals = 16'h0; ens = 4'h0; timeout = 1'b0;
        for (int p = 0; p < 4; p++) begin
            w = 0;
            while (o_digit_position != 2'(p) && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (w >= 20) timeout = 1'b1;
            vals[4*p +: 4] = o_value;
            ens[p]         = o_En;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        vectors++;
        if ({o_busy, o_overflow, o_digit_position, o_En, o_value} !== 9'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, want 000000000",
                     {o_busy, o_overflow, o_digit_position, o_En, o_value});
        end
    endtask

    task automatic test_scan;
        logic [1:0] exp_pos;
        i_display_on = 1'b1;
        rst_n        = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            exp_pos = 2'((k / 4) % 4);
            vectors++;
            if (o_digit_position !== exp_pos || o_value !== 4'd0 ||
                o_En !== (k > 0)) begin
                errors++;
                $display("FAIL scan_k%0d: got pos=%0d val=%0d en=%b, want pos=%0d val=0 en=%b",
                         k, o_digit_position, o_value, o_En, exp_pos, (k > 0));
            end
            @(negedge clk);
        end
    endtask

    task automatic load_and_check(input string name, input logic [13:0] v,
                                  input logic [15:0] exp_bcd, input logic exp_ovf);
        int n;
        logic [15:0] vals;
        logic [3:0]  ens;
        bit to;
        do_load(v);
        count_busy(n);
        vectors++;
        if (n != 15) begin
            errors++;
            $display("FAIL %s_busy_len: got %0d, want 15", name, n);
        end
        vectors++;
        if (o_overflow !== exp_ovf) begin
            errors++;
            $display("FAIL %s_overflow: got %b, want %b", name, o_overflow, exp_ovf);
        end
        read_digits(vals, ens, to);
        vectors++;
        if (to || vals !== exp_bcd) begin
            errors++;
            $display("FAIL %s_digits: got %h (timeout=%0d), want %h", name, vals, to, exp_bcd);
        end
    endtask

    task automatic test_convert;
        load_and_check("conv1234", 14'd1234, 16'h1234, 1'b0);
        load_and_check("conv0907", 14'd907,  16'h0907, 1'b0);
    endtask

    task automatic test_boundary;
        load_and_check("max9999",  14'd9999,  16'h9999, 1'b0);
        load_and_check("ovf10000", 14'd10000, 16'h9999, 1'b1);
    endtask

    task automatic test_overflow;
        load_and_check("ovf12000", 14'd12000, 16'h9999, 1'b1);
        load_and_check("after5",   14'd5,     16'h0005, 1'b0);
    endtask

    task automatic test_busy_ignore;
        int n;
        logic [15:0] vals;
        logic [3:0]  ens;
        bit to;
        do_load(14'd1234);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (o_busy) n++;
            if (c == 3) begin
                i_value = 14'd9999;
                i_load  = 1'b1;
            end else begin
                i_load  = 1'b0;
            end
            @(negedge clk);
        end
        vectors++;
        if (n != 15) begin
            errors++;
            $display("FAIL ignore_busy_total: got %0d, want 15", n);
        end
        read_digits(vals, ens, to);
        vectors++;
        if (to || vals !== 16'h1234) begin
            errors++;
            $display("FAIL ignore_digits: got %h (timeout=%0d), want 1234", vals, to);
        end
    endtask

    task automatic test_async_reset;
        int n;
        logic [15:0] vals;
        logic [3:0]  ens;
        bit to;
        do_load(14'd8765);
        repeat (6) @(negedge clk);
        vectors++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre_busy: got %b, want 1", o_busy);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({o_busy, o_En, o_value, o_digit_position} !== 8'd0) begin
            errors++;
            $display("FAIL areset_immediate: got busy=%b en=%b val=%0d pos=%0d, want all 0",
                     o_busy, o_En, o_value, o_digit_position);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        count_busy(n);
        vectors++;
        if (n != 0) begin
            errors++;
            $display("FAIL areset_no_resume: got busy cycles %0d, want 0", n);
        end
        read_digits(vals, ens, to);
        vectors++;
        if (to || vals !== 16'h0000) begin
            errors++;
            $display("FAIL areset_digits: got %h (timeout=%0d), want 0000", vals, to);
        end
    endtask

    task automatic test_blank;
        int n;
        logic [15:0] vals;
        logic [3:0]  ens;
        logic [3:0]  exp42, exp0;
        bit to;
`ifdef FND_LEADING_ZERO_BLANK_EN
        exp42 = 4'b0011;
        exp0  = 4'b0001;
`else
        exp42 = 4'b1111;
        exp0  = 4'b1111;
`endif
        do_load(14'd42);
        count_busy(n);
        repeat (2) @(negedge clk);
        read_digits(vals, ens, to);
        vectors++;
        if (to || vals !== 16'h0042 || ens !== exp42) begin
            errors++;
            $display("FAIL blank42: got val=%h en=%b (timeout=%0d), want val=0042 en=%b",
                     vals, ens, to, exp42);
        end
        do_load(14'd0);
        count_busy(n);
        repeat (2) @(negedge clk);
        read_digits(vals, ens, to);
        vectors++;
        if (to || vals !== 16'h0000 || ens !== exp0) begin
            errors++;
            $display("FAIL blank0: got val=%h en=%b (timeout=%0d), want val=0000 en=%b",
                     vals, ens, to, exp0);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_convert();
        test_boundary();
        test_overflow();
        test_busy_ignore();
        test_async_reset();
        test_blank();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
